jpeg_stream_reader: RTL and testbench



---
 rtl/jpeg_marker_pkg.sv | 33 +++
 rtl/jpeg_stream_reader_bit_window_buffer.sv | 72 +++++++
 rtl/jpeg_stream_reader.sv | 118 +++++++++++
 tb/tb_jpeg_stream_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_marker_pkg.sv
// Shared marker codes, byte-FSM state type and marker helpers for the JPEG stream reader.
package jpeg_marker_pkg;

  localparam logic [7:0] MK_SOI  = 8'hD8;
  localparam logic [7:0] MK_EOI  = 8'hD9;
  localparam logic [7:0] MK_SOS  = 8'hDA;
  localparam logic [7:0] MK_DQT  = 8'hDB;
  localparam logic [7:0] MK_DHT  = 8'hC4;
  localparam logic [7:0] MK_RST0 = 8'hD0;
  localparam logic [7:0] MK_RST1 = 8'hD1;
  localparam logic [7:0] MK_RST2 = 8'hD2;
  localparam logic [7:0] MK_RST3 = 8'hD3;
  localparam logic [7:0] MK_RST4 = 8'hD4;
  localparam logic [7:0] MK_RST5 = 8'hD5;
  localparam logic [7:0] MK_RST6 = 8'hD6;
  localparam logic [7:0] MK_RST7 = 8'hD7;

  localparam logic [7:0] BYTE_FF = 8'hFF;
  localparam logic [7:0] BYTE_00 = 8'h00;

  // Byte FSM: plain data, after a 0xFF prefix, or holding a reported marker.
  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_FF     = 2'd1,
    S_MARKER = 2'd2
  } rd_state_e;

  // RSTn markers occupy 0xD0..0xD7.
  function automatic logic is_rst(input logic [7:0] code);
    return (code[7:3] == MK_RST0[7:3]);
  endfunction

endpackage

// File: rtl/jpeg_stream_reader_bit_window_buffer.sv
// MSB-aligned bit buffer: appends whole bytes, drops variable-length prefixes,
// and flags consumes that ask for more bits than are held.
module bit_window_buffer #(
  parameter int BUF_W  = 64,
  parameter int PEEK_W = 32,
  parameter int CNT_W  = $clog2(BUF_W + 1),
  parameter int LEN_W  = $clog2(PEEK_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              append_valid,
  input  logic [7:0]        append_byte,
  input  logic              consume_valid,
  input  logic [LEN_W-1:0]  consume_len,
  input  logic              flush,
  output logic [PEEK_W-1:0] peek_bits,
  output logic [CNT_W-1:0]  bit_count,
  output logic              consume_err
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] len_ext;
  logic [BUF_W-1:0] byte_word;

  // Next buffer: flush beats everything; otherwise consume first, then the
  // byte lands directly behind whatever survived the consume. Left shifts
  // fill with zeros, so bits past the count always read as 0.
  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    len_ext   = CNT_W'(consume_len);
    byte_word = {append_byte, {(BUF_W-8){1'b0}}};
    if (flush) begin
      buf_d = '0;
      cnt_d = '0;
    end else begin
      if (consume_valid) begin
        if (len_ext > cnt_q) begin
          err_d = 1'b1;
        end else begin
          buf_d = buf_q << consume_len;
          cnt_d = cnt_q - len_ext;
        end
      end
      if (append_valid) begin
        buf_d = buf_d | (byte_word >> cnt_d);
        cnt_d = cnt_d + CNT_W'(8);
      end
    end
  end

  // Buffer, count and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign peek_bits   = buf_q[BUF_W-1 -: PEEK_W];
  assign bit_count   = cnt_q;
  assign consume_err = err_q;

endmodule

// File: rtl/jpeg_stream_reader.sv
// JPEG entropy-stream front end: strips 0xFF00 stuffing and fill bytes,
// reports markers, and feeds a bit window to the Huffman decoder.
//
// Handshakes: a byte transfers when in_valid && in_ready; in_ready depends
// only on registered state. A marker stays presented (marker_valid/marker_code)
// until marker_ack is seen while marker_valid is high. consume_valid is a
// one-cycle request with no back-pressure; illegal lengths pulse consume_err.
module jpeg_stream_reader
  import jpeg_marker_pkg::*;
#(
  parameter int BUF_W  = 64,
  parameter int PEEK_W = 32,
  parameter int CNT_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  output logic                    in_ready,
  output logic [PEEK_W-1:0]       peek_bits,
  output logic [CNT_W-1:0]        bit_count,
  input  logic                    consume_valid,
  input  logic [$clog2(PEEK_W):0] consume_len,
  output logic                    consume_err,
  output logic                    marker_valid,
  output logic [7:0]              marker_code,
  input  logic                    marker_ack
);

  localparam int               LEN_W    = $clog2(PEEK_W) + 1;
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(BUF_W - 8);

  rd_state_e   state_q, state_d;
  logic        mk_valid_q, mk_valid_d;
  logic [7:0]  mk_code_q, mk_code_d;
  logic        accept;
  logic        append_v;
  logic [7:0]  append_b;
  logic        flush;

  assign in_ready = (state_q != S_MARKER) && (bit_count <= FILL_MAX);
  assign accept   = in_valid && in_ready;

  // Byte FSM: decides what each accepted byte contributes and runs the
  // marker handshake; an RSTn acknowledgement drops the padding bits.
  always_comb begin
    state_d    = state_q;
    mk_valid_d = mk_valid_q;
    mk_code_d  = mk_code_q;
    append_v   = 1'b0;
    append_b   = in_byte;
    flush      = 1'b0;
    case (state_q)
      S_DATA: begin
        if (accept) begin
          if (in_byte == BYTE_FF) state_d  = S_FF;
          else                    append_v = 1'b1;
        end
      end
      S_FF: begin
        if (accept) begin
          if (in_byte == BYTE_00) begin
            append_v = 1'b1;
            append_b = BYTE_FF;
            state_d  = S_DATA;
          end else if (in_byte != BYTE_FF) begin
            mk_code_d  = in_byte;
            mk_valid_d = 1'b1;
            state_d    = S_MARKER;
          end
        end
      end
      S_MARKER: begin
        if (marker_ack && mk_valid_q) begin
          mk_valid_d = 1'b0;
          state_d    = S_DATA;
          flush      = is_rst(mk_code_q);
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  // FSM and marker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DATA;
      mk_valid_q <= 1'b0;
      mk_code_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      mk_valid_q <= mk_valid_d;
      mk_code_q  <= mk_code_d;
    end
  end

  assign marker_valid = mk_valid_q;
  assign marker_code  = mk_code_q;

  bit_window_buffer #(
    .BUF_W (BUF_W),
    .PEEK_W(PEEK_W),
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .append_valid (append_v),
    .append_byte  (append_b),
    .consume_valid(consume_valid),
    .consume_len  (consume_len),
    .flush        (flush),
    .peek_bits    (peek_bits),
    .bit_count    (bit_count),
    .consume_err  (consume_err)
  );

endmodule

// File: tb/tb_jpeg_stream_reader.sv
// Bench for jpeg_stream_reader: directed scenarios followed by random traffic,
// all checked against a bit-queue reference model.
module tb_jpeg_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [31:0] peek_bits;
  logic [6:0]  bit_count;
  logic        consume_valid;
  logic [5:0]  consume_len;
  logic        consume_err;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack;

  int checks = 0;
  int errors = 0;

  // Reference model: the decoder-visible bit stream as a queue, oldest bit first.
  logic [0:0] exp_q[$];
  bit         ff_seen;
  bit         m_pending;
  logic [7:0] m_code;
  bit         exp_err;

  logic [7:0] mk_tab [8];

  jpeg_stream_reader #(.BUF_W(64), .PEEK_W(32), .CNT_W(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .peek_bits    (peek_bits),
    .bit_count    (bit_count),
    .consume_valid(consume_valid),
    .consume_len  (consume_len),
    .consume_err  (consume_err),
    .marker_valid (marker_valid),
    .marker_code  (marker_code),
    .marker_ack   (marker_ack)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_peek();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32 && i < exp_q.size(); i++) r[31-i] = exp_q[i];
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic model_reset();
    exp_q.delete();
    ff_seen   = 0;
    m_pending = 0;
    m_code    = 8'h00;
    exp_err   = 0;
  endtask

  task automatic check_outputs();
    chk("peek_bits", peek_bits, model_peek());
    chk("bit_count", bit_count, exp_q.size());
    chk("marker_valid", marker_valid, m_pending);
    chk("consume_err", consume_err, exp_err);
    if (m_pending) chk("marker_code", marker_code, m_code);
  endtask

  // One clock cycle: drive inputs, predict, then check after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic cv,
                      input logic [5:0] cl, input logic ack);
    logic exp_rdy;
    logic acc;
    logic flushed;
    in_valid      = v;
    in_byte       = b;
    consume_valid = cv;
    consume_len   = cl;
    marker_ack    = ack;
    exp_rdy = !m_pending && (exp_q.size() <= 56);
    chk("in_ready", in_ready, exp_rdy);
    acc     = v && exp_rdy;
    flushed = 0;
    exp_err = 0;
    if (ack && m_pending) begin
      m_pending = 0;
      if (m_code >= 8'hD0 && m_code <= 8'hD7) begin
        exp_q.delete();
        flushed = 1;
      end
    end
    if (cv && !flushed) begin
      if (int'(cl) > exp_q.size()) exp_err = 1;
      else for (int i = 0; i < int'(cl); i++) void'(exp_q.pop_front());
    end
    if (acc) begin
      if (!ff_seen) begin
        if (b == 8'hFF) ff_seen = 1;
        else push_byte(b);
      end else if (b == 8'h00) begin
        push_byte(8'hFF);
        ff_seen = 0;
      end else if (b != 8'hFF) begin
        m_code    = b;
        m_pending = 1;
        ff_seen   = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
    in_valid      = 1'b0;
    consume_valid = 1'b0;
    marker_ack    = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    step(1'b1, b, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic take(input logic [5:0] n);
    step(1'b0, 8'h00, 1'b1, n, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_peek"}, peek_bits, 64'h0);
    chk({tag, "_count"}, bit_count, 64'h0);
    chk({tag, "_mvalid"}, marker_valid, 64'h0);
    chk({tag, "_mcode"}, marker_code, 64'h0);
    chk({tag, "_err"}, consume_err, 64'h0);
    chk({tag, "_ready"}, in_ready, 64'h1);
  endtask

  initial begin
    mk_tab = '{8'hD0, 8'hD3, 8'hD7, 8'hD8, 8'hD9, 8'hDA, 8'hDB, 8'hC4};
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    consume_valid = 1'b0; consume_len = 6'd0; marker_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_values("reset");

    // 1: two plain bytes.
    feed(8'h12); feed(8'h34);
    chk("t1_peek", peek_bits, 64'h12340000);
    chk("t1_count", bit_count, 64'd16);

    // 2: stuffed 0xFF00 then data.
    take(6'd16);
    feed(8'hFF); feed(8'h00); feed(8'hA5);
    chk("t2_peek", peek_bits, 64'hFFA50000);
    chk("t2_count", bit_count, 64'd16);

    // 3: fill byte before an RST marker, stall, then ack flushes.
    take(6'd16);
    feed(8'hAB); feed(8'hFF); feed(8'hFF); feed(8'hD3);
    chk("t3_mcode", marker_code, 64'hD3);
    chk("t3_peek", peek_bits, 64'hAB000000);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h55, 1'b0, 6'd0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
    chk("t3_count_after_ack", bit_count, 64'd0);
    chk("t3_ready_after_ack", in_ready, 64'd1);

    // 4: partial consume, then an over-long consume.
    feed(8'h12); feed(8'h34);
    take(6'd4);
    chk("t4_peek", peek_bits, 64'h23400000);
    take(6'd13);
    chk("t4_err", consume_err, 64'd1);
    chk("t4_count", bit_count, 64'd12);
    idle();
    chk("t4_err_clear", consume_err, 64'd0);

    // 5: near-full buffer with simultaneous consume and append.
    take(6'd12);
    for (int i = 1; i <= 7; i++) feed(8'(i * 8'h11));
    step(1'b1, 8'hCC, 1'b1, 6'd8, 1'b0);
    chk("t5_count56", bit_count, 64'd56);
    take(6'd7);
    chk("t5_count49", bit_count, 64'd49);
    feed(8'h77);
    chk("t5_count57", bit_count, 64'd57);
    chk("t5_ready_low", in_ready, 64'd0);
    take(6'd32); take(6'd9);
    chk("t5_cc_pos", peek_bits, 64'hCC770000);
    take(6'd16);

    // 6: EOI keeps the buffer; asynchronous reset mid-stream clears all.
    feed(8'h5A); feed(8'hFF); feed(8'hD9);
    chk("t6_mcode", marker_code, 64'hD9);
    step(1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
    chk("t6_count", bit_count, 64'd8);
    chk("t6_peek", peek_bits, 64'h5A000000);
    feed(8'h01); feed(8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    feed(8'h00);
    chk("t6_post_rst_data", bit_count, 64'd8);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 12)      b = 8'hFF;
      else if (r < 18) b = 8'h00;
      else if (r < 22) b = mk_tab[$urandom_range(0, 7)];
      else             b = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 9) < 8), b, ($urandom_range(0, 9) < 7),
           6'($urandom_range(0, 36)), ($urandom_range(0, 9) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
